// File: rtl/sprite_palette_pkg.sv
// Shared types and helpers for the sprite palette unit.
// grey_ramp gives the power-on contents of every palette entry.
package sprite_palette_pkg;

    localparam int FLASH_CNT_W = 8;
    localparam int DEF_CHAN_W  = 4;

    typedef struct packed {
        logic [DEF_CHAN_W-1:0] red;
        logic [DEF_CHAN_W-1:0] green;
        logic [DEF_CHAN_W-1:0] blue;
    } rgb_t;

    function automatic int grey_ramp(input int i, input int index_w, input int chan_w);
        return (i * ((1 << chan_w) - 1)) / ((1 << index_w) - 1);
    endfunction

endpackage

// File: rtl/sprite_palette_unit_if.sv
// Lookup request/response and palette write bus of the sprite palette unit.
// The renderer side is the master, the palette unit the slave.
interface sprite_palette_unit_if #(
    parameter int INDEX_W = 4,
    parameter int CHAN_W  = 4
);
    logic                  in_valid;
    logic [3:0]            in_pal_sel;
    logic [INDEX_W-1:0]    in_index;

    logic                  out_valid;
    logic [CHAN_W-1:0]     out_red;
    logic [CHAN_W-1:0]     out_green;
    logic [CHAN_W-1:0]     out_blue;
    logic                  out_transparent;

    logic                  wr_en;
    logic [3:0]            wr_pal;
    logic [INDEX_W-1:0]    wr_index;
    logic [3*CHAN_W-1:0]   wr_rgb;

    modport master (
        output in_valid, in_pal_sel, in_index,
        output wr_en, wr_pal, wr_index, wr_rgb,
        input  out_valid, out_red, out_green, out_blue, out_transparent
    );

    modport slave (
        input  in_valid, in_pal_sel, in_index,
        input  wr_en, wr_pal, wr_index, wr_rgb,
        output out_valid, out_red, out_green, out_blue, out_transparent
    );
endinterface

// File: rtl/palette_flash_ctrl.sv
// Frame-counted damage-flash counter; flash is shown on odd counts.
module palette_flash_ctrl
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_start,
    input  logic flash_trigger,
    output logic flash_on,
    output logic flash_active
);

    logic [FLASH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   flash_active_q, flash_active_d;

    // A trigger always wins over a frame tick, and restarts an active flash.
    always_comb begin
        cnt_d = cnt_q;
        if (flash_trigger) begin
            cnt_d = FLASH_CNT_W'(FLASH_FRAMES);
        end else if (frame_start && (cnt_q != '0)) begin
            cnt_d = cnt_q - FLASH_CNT_W'(1);
        end
        flash_active_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            flash_active_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            flash_active_q <= flash_active_d;
        end
    end

    assign flash_on     = (cnt_q != '0) && cnt_q[0];
    assign flash_active = flash_active_q;

endmodule

// File: rtl/sprite_palette_unit.sv
// Two-stage runtime-programmable palette lookup with transparency flag
// and damage-flash override.
module sprite_palette_unit
    import sprite_palette_pkg::*;
#(
    parameter int                  INDEX_W         = 4,
    parameter int                  CHAN_W          = 4,
    parameter int                  NUM_PALETTES    = 4,
    parameter int                  TRANSPARENT_IDX = 0,
    parameter int                  FLASH_FRAMES    = 8,
    parameter logic [3*CHAN_W-1:0] FLASH_RGB       = '1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sprite_palette_unit_if.slave bus,
    input  logic                 frame_start,
    input  logic                 flash_trigger,
    output logic                 flash_active
);

    localparam int         ENTRIES  = 1 << INDEX_W;
    localparam logic [4:0] NUM_PAL5 = 5'(NUM_PALETTES);

    typedef logic [3*CHAN_W-1:0] entry_t;

    entry_t     pal_q [NUM_PALETTES][ENTRIES];
    entry_t     pal_d [NUM_PALETTES][ENTRIES];
    logic       wr_hit;
    logic [3:0] rd_pal;
    entry_t     rd_rgb;
    logic       flash_on;

    logic   s1_valid_q, s1_valid_d;
    logic   s1_transparent_q, s1_transparent_d;
    logic   s1_flash_on_q, s1_flash_on_d;
    entry_t s1_rgb_q, s1_rgb_d;

    logic   out_valid_q, out_valid_d;
    logic   out_transparent_q, out_transparent_d;
    entry_t out_rgb_q, out_rgb_d;

    palette_flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .flash_trigger(flash_trigger),
        .flash_on     (flash_on),
        .flash_active (flash_active)
    );

    always_comb begin
        pal_d  = pal_q;
        wr_hit = bus.wr_en && ({1'b0, bus.wr_pal} < NUM_PAL5);
        for (int p = 0; p < NUM_PALETTES; p++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (wr_hit && (bus.wr_pal == 4'(p)) && (bus.wr_index == INDEX_W'(e))) begin
                    pal_d[p][e] = bus.wr_rgb;
                end
            end
        end
    end

    // Reads see pal_q, so a same-cycle write to the same entry returns the old value.
    always_comb begin
        rd_pal = ({1'b0, bus.in_pal_sel} < NUM_PAL5) ? bus.in_pal_sel : 4'd0;
        rd_rgb = '0;
        for (int p = 0; p < NUM_PALETTES; p++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if ((rd_pal == 4'(p)) && (bus.in_index == INDEX_W'(e))) begin
                    rd_rgb = pal_q[p][e];
                end
            end
        end
    end

    always_comb begin
        s1_valid_d       = bus.in_valid;
        s1_transparent_d = (bus.in_index == INDEX_W'(TRANSPARENT_IDX));
        s1_flash_on_d    = flash_on;
        s1_rgb_d         = rd_rgb;

        out_valid_d       = s1_valid_q;
        out_transparent_d = out_transparent_q;
        out_rgb_d         = out_rgb_q;
        if (s1_valid_q) begin
            out_transparent_d = s1_transparent_q;
            out_rgb_d = (s1_flash_on_q && !s1_transparent_q) ? FLASH_RGB : s1_rgb_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PALETTES; p++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    pal_q[p][e] <= {3{CHAN_W'(grey_ramp(e, INDEX_W, CHAN_W))}};
                end
            end
            s1_valid_q        <= 1'b0;
            s1_transparent_q  <= 1'b0;
            s1_flash_on_q     <= 1'b0;
            s1_rgb_q          <= '0;
            out_valid_q       <= 1'b0;
            out_transparent_q <= 1'b0;
            out_rgb_q         <= '0;
        end else begin
            pal_q             <= pal_d;
            s1_valid_q        <= s1_valid_d;
            s1_transparent_q  <= s1_transparent_d;
            s1_flash_on_q     <= s1_flash_on_d;
            s1_rgb_q          <= s1_rgb_d;
            out_valid_q       <= out_valid_d;
            out_transparent_q <= out_transparent_d;
            out_rgb_q         <= out_rgb_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_transparent = out_transparent_q;
    assign bus.out_red         = out_rgb_q[3*CHAN_W-1:2*CHAN_W];
    assign bus.out_green       = out_rgb_q[2*CHAN_W-1:CHAN_W];
    assign bus.out_blue        = out_rgb_q[CHAN_W-1:0];

endmodule

// File: doc/sprite_palette_unit.md
# sprite_palette_unit

- Pipelined, runtime-programmable colour lookup for sprite and tile renderers.
- Maps a per-pixel colour index plus a palette select to 3-channel RGB. Holds `NUM_PALETTES` independently writable palettes, e.g. per-tank team tints.
- Flags a transparent-key index and supports a frame-counted damage-flash override.
- Sits between sprite ROM index readout and the VGA colour mux. Replaces the fixed per-sprite palette lookups.

## Interface
Parameters:
- `INDEX_W`, 4: colour index width; each palette has 2^`INDEX_W` entries.
- `CHAN_W`, 4: bits per colour channel.
- `NUM_PALETTES`, 4: number of palettes; 1..16.
- `TRANSPARENT_IDX`, 0: index reported as transparent.
- `FLASH_FRAMES`, 8: frame count loaded by a flash trigger; 1..255.
- `FLASH_RGB`, all ones: colour forced during flash-on frames; 3*`CHAN_W` bits.

Ports:
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pixel lookup request.
- `in_pal_sel`  in  4  palette select.
- `in_index`  in  `INDEX_W`  colour index.
- `out_valid`  out  1  result valid.
- `out_red`, `out_green`, `out_blue`  out  `CHAN_W` each  colour.
- `out_transparent`  out  1  the request's index equalled `TRANSPARENT_IDX`.
- `wr_en`  in  1  palette entry write.
- `wr_pal`  in  4  palette to write.
- `wr_index`  in  `INDEX_W`  entry to write.
- `wr_rgb`  in  3*`CHAN_W`  {R,G,B} value.
- `frame_start`  in  1  one-cycle pulse per video frame.
- `flash_trigger`  in  1  start or restart flash.
- `flash_active`  out  1  flash counter nonzero.

## Operation
- **Palette storage:** `NUM_PALETTES` x 2^`INDEX_W` register entries.
  - Reset value of entry i in every palette: each channel = floor(i*(2^`CHAN_W`-1)/(2^`INDEX_W`-1)), a grey ramp. With 4/4 parameters, entry 5 = {5,5,5}.
- **Write:** on `wr_en`, entry [`wr_pal`][`wr_index`] <= `wr_rgb`.
  - Writes with `wr_pal` >= `NUM_PALETTES` are ignored.
- **Lookup:** `in_pal_sel` >= `NUM_PALETTES` reads palette 0.
- **Transparency:** `out_transparent` = (index == `TRANSPARENT_IDX`).
  - RGB is still the stored entry; the downstream mux decides what to draw.
- **Flash counter** (8 bits):
  - `flash_trigger` loads `FLASH_FRAMES`.
  - Otherwise `frame_start` decrements it while it is nonzero.
  - Trigger and `frame_start` in the same cycle: load wins.
  - Trigger while already active restarts the count at `FLASH_FRAMES`.
  - Flash-on condition: counter nonzero and counter[0] == 1.
- **Flash override:** RGB = `FLASH_RGB` for pixels that are flash-on and not transparent. Transparent pixels are never overridden.
- The flash-on condition is sampled in stage 1, alongside the index.

## Timing
- Two-stage pipeline with no backpressure. One request accepted per cycle, sustained.
- Latency: request at cycle N produces outputs at the edge ending cycle N+2. `out_valid` is `in_valid` delayed 2.
- Outputs while `out_valid` = 0 hold their last values. The bench checks them only when valid.
- **Stage 1:** registers index, transparent flag, flash-on bit and valid, and reads the palette entry.
- **Stage 2:** applies the override and registers the outputs.
- **Write/read collision:** a write and a lookup to the same entry in the same cycle return the old value. The write is visible to requests issued from the next cycle on.
- **Reset behaviour** (asynchronous assert, synchronous release by the system):
  - Outputs on reset: `out_valid`=0, RGB=0, `out_transparent`=0, `flash_active`=0.
  - Reset restores palettes to the grey ramp and clears the flash counter and all pipeline state.
  - In-flight requests are dropped.
- `flash_active` is registered and follows the counter in the same cycle the counter updates.

## Structure
- Package `sprite_palette_pkg`:
  - `rgb_t` struct {red, green, blue}.
  - `FLASH_CNT_W` = 8.
  - Function `grey_ramp(i)` used for reset values.
- One sub-module, `palette_flash_ctrl`, holds the flash counter and produces `flash_on`/`flash_active`.
- Storage and pipeline stay in the top module.

## Test plan
- **Reset and defaults:** after reset, request pal 2 idx 9 -> two cycles later `out_valid`=1, RGB {9,9,9}, `out_transparent`=0. A request with idx 0 -> `out_transparent`=1.
- **Write then read:** write pal 1 idx 3 = {F,0,0}; request pal 1 idx 3 in the next cycle -> {F,0,0}. Pal 0 idx 3 stays {3,3,3}.
- **Collision:** same-cycle write {0,F,0} and request to pal 0 idx 4 -> {4,4,4}; the next request returns {0,F,0}.
- **Out of range:** with `NUM_PALETTES`=3, write pal 3 is ignored; request pal 3 idx 7 returns palette 0 entry 7.
- **Flash:** trigger with `FLASH_FRAMES`=4, then stream idx 5 across frames:
  - Counter sequence 4, 3, 2, 1, 0.
  - Output {F,F,F} only while the counter is 3 or 1.
  - Idx 0 pixels are never overridden.
  - `flash_active` drops when the count reaches 0.
  - Trigger coincident with `frame_start` -> counter = 4.
- **Throughput and reset:** back-to-back requests for 64 cycles produce no gaps. Asserting `reset_n` low mid-stream -> `out_valid` goes 0 immediately and a previously written entry returns to the grey ramp.
